sp_frame_master: RTL and testbench
==================================

// Module: sp_frame_master
// PURPOSE
//  Synthesizable initiator for the SP stream interface: drives clk-domain in_valid/in_data/in_mode/cg_en
//  into SP and collects SP's out_valid/out_data response. Host loads one frame over a valid/ready port;
//  block replays it to SP as one contiguous burst, captures the result burst, returns it via valid/ready.
//  Sits between on-chip host logic (or FPGA bring-up wrapper) and the SP core.
// PARAMETERS
//  IN_LEN   9     words per SP input frame (in_valid high for exactly IN_LEN consecutive cycles)
//  OUT_LEN  3     words per SP response burst
//  DW       9     data width (in_data / out_data / host_data / res_data)
//  MW       3     mode width (in_mode / host_mode)
//  TIMEOUT  1000  max cycles in WAIT before abort; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk        in   1   single clock
//  rst_n      in   1   asynchronous active-low reset
//  cfg_cg_en  in   1   clock-gating enable request, forwarded to SP
//  host_valid in   1   host word valid
//  host_ready out  1   block accepts host word
//  host_data  in   DW  frame word
//  host_mode  in   MW  frame mode; sampled only with frame word 0
//  res_valid  out  1   result word valid
//  res_ready  in   1   host accepts result word
//  res_data   out  DW  result word
//  res_last   out  1   marks word OUT_LEN-1
//  timeout    out  1   one-cycle pulse on WAIT abort
//  err        out  1   sticky protocol error; cleared only by reset
//  cg_en      out  1   to SP; registered copy of cfg_cg_en
//  in_valid   out  1   to SP
//  in_data    out  DW  to SP
//  in_mode    out  MW  to SP
//  out_valid  in   1   from SP
//  out_data   in   DW  from SP
// BEHAVIOUR
//  Reset: all outputs 0, state LOAD, counters 0, buffers 0. All SP-side outputs registered.
//  FSM LOAD -> SEND -> WAIT -> DRAIN -> LOAD; WAIT -> LOAD on timeout.
//  LOAD: host_ready=1 while wcnt<IN_LEN; word stored on host_valid&host_ready; word 0 also latches
//   host_mode. On IN_LEN-th accept -> SEND next cycle; host_ready low in all other states.
//  SEND: in_valid=1 for exactly IN_LEN cycles, in_data=buf[k] k=0..IN_LEN-1 in order;
//   in_mode=latched mode on k=0, 0 on k>0. After last word -> WAIT, in_valid/in_data/in_mode=0.
//  SP sees first in_valid 1 cycle after the final host accept (registered drive).
//  WAIT: tcnt increments each cycle; each out_valid=1 stores out_data into rbuf[rcnt], rcnt++.
//   Gaps in out_valid allowed. rcnt==OUT_LEN -> DRAIN. tcnt reaches TIMEOUT with rcnt<OUT_LEN ->
//   pulse timeout, discard partial result, -> LOAD.
//  DRAIN: res_valid=1, res_data=rbuf[dcnt], res_last=(dcnt==OUT_LEN-1); advance on res_ready.
//   Last accept -> LOAD, res_valid=0 next cycle. No result shown before all OUT_LEN words captured.
//  out_valid=1 outside WAIT (LOAD/SEND/DRAIN) or on same cycle as SEND in_valid: sets err, word dropped.
//  out_valid while in_valid=1 in the same cycle is always an error (SP must not overlap).
//  in_valid never deasserts mid-frame; host stall cannot break a burst (frame fully buffered first).
//  cg_en: cfg_cg_en delayed 1 cycle; may change at any time, independent of FSM.
//  Async reset mid-frame: everything returns to reset values; partial frame/result lost.
//  Counters saturate-free: wcnt/k/dcnt width $clog2(max(IN_LEN,OUT_LEN)+1), cleared on state entry.
// STRUCTURE
//  sp_pkg: state enum {LOAD,SEND,WAIT,DRAIN}, DW/MW/IN_LEN/OUT_LEN defaults, TIMEOUT default.
//  Sub-module sp_frame_buf (DEPTH x DW register array, write port + indexed read port),
//   instantiated twice: input frame (DEPTH=IN_LEN), result (DEPTH=OUT_LEN).
//  Top: FSM, counters, SP-side output registers, err/timeout logic.
// TESTING
//  T1 load 1..9, mode=3'd5; SP model returns 7,8,9 -> in_valid 9 cycles, in_mode=5 only cycle 0,
//     in_data 1..9; res 7,8,9 with res_last on 9.
//  T2 host_valid toggled every other cycle during LOAD -> SP burst still 9 contiguous cycles.
//  T3 SP returns 3 words with 2-cycle gaps, res_ready held low 5 cycles in DRAIN -> data held
//     stable, no loss, order 3 words preserved.
//  T4 SP never raises out_valid, TIMEOUT=20 -> timeout pulse exactly once 20 cycles into WAIT,
//     state LOAD, host_ready=1 next cycle, res_valid never 1.
//  T5 out_valid=1 during SEND -> err=1 and stays 1; next full frame still completes correctly.
//  T6 rst_n low mid-SEND (cycle 4) -> in_valid=0 immediately, all outputs 0; new frame after
//     release runs as T1; toggle cfg_cg_en -> cg_en follows 1 cycle later.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared types and default sizing for the SP frame master.
package sp_pkg;

  typedef enum logic [1:0] {LOAD, SEND, WAIT, DRAIN} state_e;

  localparam int SP_DW      = 9;
  localparam int SP_MW      = 3;
  localparam int SP_IN_LEN  = 9;
  localparam int SP_OUT_LEN = 3;
  localparam int SP_TIMEOUT = 1000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sp_frame_buf.sv
// Small register-array frame buffer: one write port, one indexed read port.
module sp_frame_buf
  import sp_pkg::*;
#(
  parameter int DEPTH = SP_IN_LEN,
  parameter int DW    = SP_DW,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // Next contents: single-word update on write enable.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sp_frame_master.sv
// Buffers one host frame, replays it to SP as a contiguous burst, captures
// the SP response burst and hands it back to the host over valid/ready.
module sp_frame_master
  import sp_pkg::*;
#(
  parameter int IN_LEN  = SP_IN_LEN,
  parameter int OUT_LEN = SP_OUT_LEN,
  parameter int DW      = SP_DW,
  parameter int MW      = SP_MW,
  parameter int TIMEOUT = SP_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_cg_en,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [DW-1:0] host_data,
  input  logic [MW-1:0] host_mode,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_last,
  output logic          timeout,
  output logic          err,
  output logic          cg_en,
  output logic          in_valid,
  output logic [DW-1:0] in_data,
  output logic [MW-1:0] in_mode,
  input  logic          out_valid,
  input  logic [DW-1:0] out_data
);

  localparam int CW  = $clog2(max2(IN_LEN, OUT_LEN) + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int IAW = (IN_LEN > 1)  ? $clog2(IN_LEN)  : 1;
  localparam int RAW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam logic [CW-1:0] IN_LAST  = CW'(IN_LEN - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(OUT_LEN - 1);
  localparam logic [TW-1:0] TO_VAL   = TW'(TIMEOUT);

  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d, kcnt_q, kcnt_d, rcnt_q, rcnt_d, dcnt_q, dcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [MW-1:0] mode_q, mode_d;
  logic          host_ready_q, host_ready_d, res_valid_q, res_valid_d;
  logic          timeout_q, timeout_d, err_q, err_d, cg_en_q, cg_en_d;
  logic          in_valid_q, in_valid_d;
  logic [DW-1:0] in_data_q, in_data_d;
  logic [MW-1:0] in_mode_q, in_mode_d;
  logic [IAW-1:0] ird;
  logic [DW-1:0] ibuf_rd;
  logic          host_acc, res_we;

  assign host_acc = host_valid & host_ready_q;
  assign res_we   = (state_q == WAIT) & out_valid;

  sp_frame_buf #(.DEPTH(IN_LEN), .DW(DW), .AW(IAW)) u_ibuf (
    .clk(clk), .rst_n(rst_n), .we(host_acc), .waddr(wcnt_q[IAW-1:0]),
    .wdata(host_data), .raddr(ird), .rdata(ibuf_rd)
  );

  sp_frame_buf #(.DEPTH(OUT_LEN), .DW(DW), .AW(RAW)) u_rbuf (
    .clk(clk), .rst_n(rst_n), .we(res_we), .waddr(rcnt_q[RAW-1:0]),
    .wdata(out_data), .raddr(dcnt_q[RAW-1:0]), .rdata(res_data)
  );

  // Next-state, counters and registered-output values for every state.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    kcnt_d       = kcnt_q;
    rcnt_d       = rcnt_q;
    dcnt_d       = dcnt_q;
    tcnt_d       = tcnt_q;
    mode_d       = mode_q;
    host_ready_d = 1'b0;
    res_valid_d  = 1'b0;
    timeout_d    = 1'b0;
    in_valid_d   = 1'b0;
    in_data_d    = '0;
    in_mode_d    = '0;
    ird          = '0;
    cg_en_d      = cfg_cg_en;
    // Any SP response outside WAIT (including overlap with our burst) is a protocol error.
    err_d        = err_q | (out_valid & (state_q != WAIT));
    case (state_q)
      LOAD: begin
        host_ready_d = 1'b1;
        if (host_acc) begin
          if (wcnt_q == '0) mode_d = host_mode;
          if (wcnt_q == IN_LAST) begin
            // Launch word 0 on the same edge so SP sees it one cycle after the last accept.
            state_d      = SEND;
            host_ready_d = 1'b0;
            wcnt_d       = '0;
            kcnt_d       = '0;
            in_valid_d   = 1'b1;
            in_data_d    = (IN_LEN == 1) ? host_data : ibuf_rd;
            in_mode_d    = (IN_LEN == 1) ? host_mode : mode_q;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      SEND: begin
        if (kcnt_q == IN_LAST) begin
          state_d = WAIT;
          tcnt_d  = '0;
          rcnt_d  = '0;
        end else begin
          kcnt_d     = kcnt_q + 1'b1;
          ird        = kcnt_d[IAW-1:0];
          in_valid_d = 1'b1;
          in_data_d  = ibuf_rd;
        end
      end
      WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        if (out_valid) rcnt_d = rcnt_q + 1'b1;
        // A completed result wins over a simultaneous timeout.
        if (out_valid && (rcnt_q == OUT_LAST)) begin
          state_d     = DRAIN;
          dcnt_d      = '0;
          res_valid_d = 1'b1;
        end else if (tcnt_d == TO_VAL) begin
          state_d      = LOAD;
          wcnt_d       = '0;
          timeout_d    = 1'b1;
          host_ready_d = 1'b1;
        end
      end
      DRAIN: begin
        res_valid_d = 1'b1;
        if (res_ready) begin
          if (dcnt_q == OUT_LAST) begin
            state_d      = LOAD;
            wcnt_d       = '0;
            res_valid_d  = 1'b0;
            host_ready_d = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // FSM state, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      wcnt_q       <= '0;
      kcnt_q       <= '0;
      rcnt_q       <= '0;
      dcnt_q       <= '0;
      tcnt_q       <= '0;
      mode_q       <= '0;
      host_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      timeout_q    <= 1'b0;
      err_q        <= 1'b0;
      cg_en_q      <= 1'b0;
      in_valid_q   <= 1'b0;
      in_data_q    <= '0;
      in_mode_q    <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      kcnt_q       <= kcnt_d;
      rcnt_q       <= rcnt_d;
      dcnt_q       <= dcnt_d;
      tcnt_q       <= tcnt_d;
      mode_q       <= mode_d;
      host_ready_q <= host_ready_d;
      res_valid_q  <= res_valid_d;
      timeout_q    <= timeout_d;
      err_q        <= err_d;
      cg_en_q      <= cg_en_d;
      in_valid_q   <= in_valid_d;
      in_data_q    <= in_data_d;
      in_mode_q    <= in_mode_d;
    end
  end

  assign host_ready = host_ready_q;
  assign res_valid  = res_valid_q;
  assign res_last   = res_valid_q & (dcnt_q == OUT_LAST);
  assign timeout    = timeout_q;
  assign err        = err_q;
  assign cg_en      = cg_en_q;
  assign in_valid   = in_valid_q;
  assign in_data    = in_data_q;
  assign in_mode    = in_mode_q;

endmodule

// File: tb/tb_sp_frame_master.sv
// Directed bench for sp_frame_master: frame replay, response capture/drain,
// timeout, protocol error, mid-frame reset and clock-gate enable forwarding.
module tb_sp_frame_master;

  localparam int DW = 9, MW = 3, IN_LEN = 9, OUT_LEN = 3, TO = 20;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cfg_cg_en = 1'b0, host_valid = 1'b0, res_ready = 1'b0, out_valid = 1'b0;
  logic [DW-1:0] host_data = '0, out_data = '0;
  logic [MW-1:0] host_mode = '0;
  logic          host_ready, res_valid, res_last, timeout, err, cg_en, in_valid;
  logic [DW-1:0] res_data, in_data;
  logic [MW-1:0] in_mode;

  int checks = 0, errors = 0;
  logic [DW-1:0] frame [IN_LEN];
  logic [DW-1:0] rsp   [OUT_LEN];

  sp_frame_master #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .DW(DW), .MW(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_cg_en(cfg_cg_en),
    .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data), .host_mode(host_mode),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .timeout(timeout), .err(err), .cg_en(cg_en),
    .in_valid(in_valid), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_host_ready"}, host_ready, 0);
    chk({tag, "_res_valid"},  res_valid,  0);
    chk({tag, "_res_data"},   res_data,   0);
    chk({tag, "_res_last"},   res_last,   0);
    chk({tag, "_timeout"},    timeout,    0);
    chk({tag, "_err"},        err,        0);
    chk({tag, "_cg_en"},      cg_en,      0);
    chk({tag, "_in_valid"},   in_valid,   0);
    chk({tag, "_in_data"},    in_data,    0);
    chk({tag, "_in_mode"},    in_mode,    0);
  endtask

  // Push frame[] to the host port; mode only legitimately rides on word 0.
  task automatic load_frame(input logic [MW-1:0] m, input bit gap);
    for (int i = 0; i < IN_LEN; i++) begin
      int n;
      n = 0;
      host_valid = 1'b1;
      host_data  = frame[i];
      host_mode  = (i == 0) ? m : ~m;
      while (host_ready !== 1'b1 && n < 50) begin step(); n++; end
      chk("load_host_ready", host_ready, 1);
      step();
      host_valid = 1'b0;
      if (gap && i != IN_LEN - 1) step();
    end
  endtask

  // Check the SP burst word by word; optionally inject a stray out_valid at word inj.
  task automatic send_check(input logic [MW-1:0] m, input int inj);
    for (int k = 0; k < IN_LEN; k++) begin
      chk("burst_in_valid", in_valid, 1);
      chk("burst_in_data",  in_data,  frame[k]);
      chk("burst_in_mode",  in_mode,  (k == 0) ? m : 0);
      chk("burst_host_ready", host_ready, 0);
      if (k == inj) begin out_valid = 1'b1; out_data = 9'h1AA; end
      step();
      out_valid = 1'b0;
    end
    chk("burst_end_in_valid", in_valid, 0);
    chk("burst_end_in_data",  in_data,  0);
  endtask

  // SP model: return rsp[] with gap idle cycles between words.
  task automatic sp_reply(input int gap);
    for (int j = 0; j < OUT_LEN; j++) begin
      out_valid = 1'b1;
      out_data  = rsp[j];
      step();
      out_valid = 1'b0;
      if (j < OUT_LEN - 1)
        for (int g = 0; g < gap; g++) begin
          chk("reply_no_early_res", res_valid, 0);
          step();
        end
    end
  endtask

  // Drain the result, first holding res_ready low for hold cycles.
  task automatic drain(input int hold);
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_data",  res_data,  rsp[0]);
      step();
    end
    res_ready = 1'b1;
    for (int j = 0; j < OUT_LEN; j++) begin
      chk("drain_res_valid", res_valid, 1);
      chk("drain_res_data",  res_data,  rsp[j]);
      chk("drain_res_last",  res_last,  (j == OUT_LEN - 1) ? 1 : 0);
      step();
    end
    res_ready = 1'b0;
    chk("drain_done_res_valid", res_valid, 0);
    chk("drain_done_host_ready", host_ready, 1);
  endtask

  initial begin
    int n;
    bit rv;
    // Reset state
    step(); step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk("post_reset_host_ready", host_ready, 1);

    // T1: 1..9, mode 5, response 7,8,9
    for (int i = 0; i < IN_LEN; i++) frame[i] = 9'(i + 1);
    rsp[0] = 9'd7; rsp[1] = 9'd8; rsp[2] = 9'd9;
    load_frame(3'd5, 1'b0);
    send_check(3'd5, -1);
    sp_reply(0);
    drain(0);

    // T2: host_valid toggled every other cycle, burst must stay contiguous
    for (int i = 0; i < IN_LEN; i++) frame[i] = 9'(9'h10 + i);
    rsp[0] = 9'h101; rsp[1] = 9'h0F0; rsp[2] = 9'h055;
    load_frame(3'd2, 1'b1);
    send_check(3'd2, -1);
    sp_reply(0);
    drain(0);

    // T3: gapped response, host back-pressure for 5 cycles
    for (int i = 0; i < IN_LEN; i++) frame[i] = 9'(3 * i + 100);
    rsp[0] = 9'h1FF; rsp[1] = 9'h000; rsp[2] = 9'h123;
    load_frame(3'd7, 1'b0);
    send_check(3'd7, -1);
    sp_reply(2);
    drain(5);
    chk("t3_err_clear", err, 0);

    // T4: SP silent -> single timeout pulse 20 cycles into WAIT
    for (int i = 0; i < IN_LEN; i++) frame[i] = 9'(9'h1F0 - i);
    load_frame(3'd1, 1'b0);
    send_check(3'd1, -1);
    n = 0; rv = 1'b0;
    while (timeout !== 1'b1 && n < 100) begin
      step(); n++;
      if (res_valid === 1'b1) rv = 1'b1;
    end
    chk("t4_timeout_cycles", n, TO);
    chk("t4_timeout_pulse", timeout, 1);
    step();
    chk("t4_timeout_one_cycle", timeout, 0);
    chk("t4_host_ready", host_ready, 1);
    for (int i = 0; i < 5; i++) begin
      if (timeout === 1'b1 || res_valid === 1'b1) rv = 1'b1;
      step();
    end
    chk("t4_no_res_no_repulse", rv, 0);
    chk("t4_err_clear", err, 0);

    // T5: stray out_valid during SEND -> sticky err, later frames still work
    for (int i = 0; i < IN_LEN; i++) frame[i] = 9'(9'h0A0 + 2 * i);
    rsp[0] = 9'h011; rsp[1] = 9'h022; rsp[2] = 9'h033;
    load_frame(3'd6, 1'b0);
    send_check(3'd6, 3);
    chk("t5_err_set", err, 1);
    sp_reply(0);
    drain(0);
    for (int i = 0; i < IN_LEN; i++) frame[i] = 9'(i + 1);
    rsp[0] = 9'd7; rsp[1] = 9'd8; rsp[2] = 9'd9;
    load_frame(3'd5, 1'b0);
    send_check(3'd5, -1);
    sp_reply(0);
    drain(0);
    chk("t5_err_sticky", err, 1);

    // T6: async reset at burst word 4
    for (int i = 0; i < IN_LEN; i++) frame[i] = 9'(9'h150 + i);
    load_frame(3'd3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("t6_burst_data", in_data, frame[k]);
      step();
    end
    chk("t6_pre_reset_in_valid", in_valid, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_reset");
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < IN_LEN; i++) frame[i] = 9'(i + 1);
    rsp[0] = 9'd7; rsp[1] = 9'd8; rsp[2] = 9'd9;
    load_frame(3'd5, 1'b0);
    send_check(3'd5, -1);
    sp_reply(0);
    drain(0);
    chk("t6_err_clear", err, 0);

    // cg_en follows cfg_cg_en one cycle later
    cfg_cg_en = 1'b1;
    #1;
    chk("cg_before_edge", cg_en, 0);
    step();
    chk("cg_rise", cg_en, 1);
    cfg_cg_en = 1'b0;
    #1;
    chk("cg_hold", cg_en, 1);
    step();
    chk("cg_fall", cg_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
